// File: rtl/fifo_drain_ctrl.sv
// Drain stage between a synchronous FIFO and a valid/ready consumer, using a 2-entry skid buffer.
// Define FIFO_DRAIN_STATS_EN to enable the pop counter and the sticky underflow flag.
module fifo_drain_ctrl #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  empty_i,
   input  logic                  underflow_i,
   input  logic [FIFO_WIDTH-1:0] data_out_i,
   output logic                  rd_en_o,
   output logic                  m_valid_o,
   output logic [FIFO_WIDTH-1:0] m_data_o,
   input  logic                  m_ready_i,
   input  logic                  stats_clr_i,
   output logic [CNT_WIDTH-1:0]  pop_cnt_o,
   output logic                  err_underflow_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ONE  = 2'd1;
   localparam logic [1:0] TWO  = 2'd2;

   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic                  wr_ptr_q, rd_ptr_q;
   logic [FIFO_WIDTH-1:0] mem_q [2];
   logic                  pop, land;
   logic [1:0]            level;

   assign land      = inflight_q;
   assign m_valid_o = (occ_q != IDLE);
   assign m_data_o  = mem_q[rd_ptr_q];
   assign pop       = m_valid_o & m_ready_i;

   // Words owned after this cycle: buffered plus in flight, minus the one leaving now.
   assign level   = occ_q + {1'b0, inflight_q} - {1'b0, pop};
   assign rd_en_o = ~empty_i & (level < 2'd2);

   always_comb begin
      occ_d = occ_q;
      case (occ_q)
         IDLE: if (land) occ_d = ONE;
         ONE: begin
            if (land && !pop)      occ_d = TWO;
            else if (pop && !land) occ_d = IDLE;
         end
         TWO: if (pop && !land) occ_d = ONE;
         default: occ_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= IDLE;
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= rd_en_o;
         if (land) begin
            mem_q[wr_ptr_q] <= data_out_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

`ifdef FIFO_DRAIN_STATS_EN
   logic [CNT_WIDTH-1:0] pop_cnt_q;
   logic                 err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_cnt_q <= '0;
         err_q     <= 1'b0;
      end else if (stats_clr_i) begin
         pop_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (pop && (pop_cnt_q != {CNT_WIDTH{1'b1}})) begin
            pop_cnt_q <= pop_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
         if (underflow_i) err_q <= 1'b1;
      end
   end

   assign pop_cnt_o       = pop_cnt_q;
   assign err_underflow_o = err_q;
`else
   logic unused_stats;
   assign unused_stats    = stats_clr_i ^ underflow_i;
   assign pop_cnt_o       = '0;
   assign err_underflow_o = 1'b0;
`endif

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Downstream drain stage for the synchronous FIFO. Issues `rd_en` into the FIFO, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents words to the consumer on a valid/ready stream at up to one word per cycle. Optional pop and underflow statistics are available for debug.

## Interface
- `FIFO_WIDTH`, 16: data width; matches the FIFO's `data_out`.
- `CNT_WIDTH`, 16: width of the pop statistics counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `empty`  in  1  FIFO empty flag, combinational from the FIFO count.
- `underflow`  in  1  FIFO underflow flag, registered in the FIFO.
- `data_out`  in  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted `rd_en`.
- `rd_en`  out  1  FIFO read request.
- `m_valid`  out  1  output word available.
- `m_data`  out  FIFO_WIDTH  output word (head of the skid buffer).
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid && m_ready`.
- `stats_clr`  in  1  synchronous clear of the statistics.
- `pop_cnt`  out  CNT_WIDTH  count of words delivered to the consumer.
- `err_underflow`  out  1  sticky underflow flag.

## Operation
- **State:**
  - `occ` ∈ {0,1,2} is the skid-buffer occupancy; the encoding is IDLE=0, ONE=1, TWO=2.
  - `inflight` is a 1-bit register, set the cycle after `rd_en` is asserted.
- **Pop:** `pop = m_valid && m_ready`. Delivery order equals FIFO read order (head/tail pointers over 2 entries, wrapping modulo 2).
- **Read request:** `rd_en = !empty && (occ + inflight - pop) < 2`.
  - `rd_en` is combinational and depends on `m_ready`.
  - `rd_en` is never asserted while `empty` is 1, so the block never causes a FIFO underflow.
- **Land:** when `inflight` is 1, `data_out` is written to the tail entry that cycle.
- **Occupancy update:** `occ_next = occ + inflight - pop`.
  - A simultaneous land and pop leaves `occ` unchanged and advances both pointers.
  - A land with `occ==2` is impossible by construction. The bench asserts this.
- **Output:**
  - `m_valid = (occ != 0)`.
  - `m_data` = the head entry.
  - `m_data` holds stable while `m_valid && !m_ready`.
- **State transitions:**
  - IDLE→ONE on land.
  - ONE→TWO on land without pop.
  - TWO→ONE on pop without land.
  - ONE→IDLE on pop without land.
  - All other combinations stay in the current state.

## Timing
- **Reset values:** while `rst_n` is low, `rd_en`=0, `m_valid`=0, `m_data`=0, `occ`=0, `inflight`=0, pointers=0, `pop_cnt`=0, `err_underflow`=0.
- **Reset mid-operation:** buffered and in-flight words are discarded. The FIFO shares the same reset, so no data is lost silently.
- **Latency:** a word in the FIFO with the block IDLE appears on `m_valid` 2 cycles after `rd_en` (issue in cycle N, land at the N+1 edge, `m_valid` high from N+2).
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, `rd_en` stays at 1 and one word is delivered per cycle.
- **Backpressure:**
  - With `m_ready`=0, at most 2 words are absorbed: 1 buffered plus 1 in flight, or 2 buffered.
  - `rd_en` then drops to 0.
  - `rd_en` reasserts in the same cycle `m_ready` returns to 1.

## Configuration
- **`FIFO_DRAIN_STATS_EN` defined:**
  - `pop_cnt` increments on each `pop` and saturates at all-ones.
  - `err_underflow` sets on `underflow`=1 and stays set.
  - `stats_clr`=1 clears both on the next edge. Clear takes priority over a same-cycle increment or set.
- **`FIFO_DRAIN_STATS_EN` not defined:**
  - `pop_cnt` is tied to 0 and `err_underflow` is tied to 0.
  - `stats_clr` is ignored.
  - Data-path behaviour is identical.

## Test plan
- **Single word:** reset, push 0xA5A5 into the FIFO, `m_ready`=1 → `rd_en` pulses 1 cycle, `m_valid`=1 with `m_data`=0xA5A5 for exactly 1 cycle, `pop_cnt`=1.
- **Streaming:** 8 words 0x0001..0x0008 preloaded, `m_ready`=1 → `rd_en` high 8 consecutive cycles, output 0x0001..0x0008 in order on consecutive cycles, no bubbles.
- **Backpressure:** 4 words preloaded, `m_ready`=0 for 10 cycles → exactly 2 `rd_en` pulses, `m_valid`=1 with `m_data` frozen at word 1. Then `m_ready`=1 → words 1..4 delivered in order, back to back.
- **Empty guard:** FIFO empty, `m_ready`=1 for 20 cycles → `rd_en`=0 throughout, FIFO `underflow` stays 0, `m_valid`=0.
- **Reset mid-stream:** assert `rst_n`=0 while `occ`=2 → `m_valid`, `rd_en` and `pop_cnt` are 0 immediately (asynchronous). After release with an empty FIFO, `m_valid` stays 0.
- **Stats (macro defined):** force `underflow`=1 for 1 cycle → `err_underflow`=1 and sticky. Then `stats_clr`=1 → `err_underflow`=0 and `pop_cnt`=0 the next cycle. With `CNT_WIDTH`=4 and 20 pops → `pop_cnt`=0xF.
